// File: rtl/channel_sink_buffer_if.sv
// Fabric-side and engine-side channel bundle for the sink buffer.
// The slave modport is the buffer's view; the master modport is the driving environment's view.
interface channel_sink_buffer_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 8,
    parameter int LATENCY_WIDTH = 3
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                     in_valid;
    logic [DATA_WIDTH-1:0]    in_data;
    logic                     in_ready;
    logic [LATENCY_WIDTH-1:0] in_latency;
    logic                     out_valid;
    logic [DATA_WIDTH-1:0]    out_data;
    logic                     out_ready;
    logic [CNT_W-1:0]         count;
    logic                     empty;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, in_latency, out_valid, out_data, count, empty
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, in_latency, out_valid, out_data, count, empty
    );
endinterface

// File: rtl/channel_sink_buffer.sv
// Terminating sink of the switch channel network: a first-word-fall-through FIFO toward the engine,
// plus a registered, saturating occupancy metric returned upstream for routing decisions.
module channel_sink_buffer #(
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 8,
    parameter int LATENCY_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    channel_sink_buffer_if.slave  bus
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int LAT_MAX = (1 << LATENCY_WIDTH) - 1;

    logic [DATA_WIDTH-1:0]    mem_q [DEPTH];
    logic [DATA_WIDTH-1:0]    mem_d [DEPTH];
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic [LATENCY_WIDTH-1:0] in_latency_q, in_latency_d;
    logic                     full_s, nonempty_s, push_s, pop_s;

    function automatic logic [LATENCY_WIDTH-1:0] sat_latency(input logic [CNT_W-1:0] c);
        logic [LATENCY_WIDTH-1:0] r;
        if (int'(c) >= LAT_MAX) begin
            r = LATENCY_WIDTH'(LAT_MAX);
        end else begin
            r = LATENCY_WIDTH'(c);
        end
        return r;
    endfunction

    // Handshake qualification and next-state for storage, pointers, occupancy and latency metric.
    always_comb begin
        full_s       = (count_q == CNT_W'(DEPTH));
        nonempty_s   = (count_q != {CNT_W{1'b0}});
        push_s       = bus.in_valid && !full_s;
        pop_s        = bus.out_ready && nonempty_s;
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        // The metric trails occupancy by one cycle; the fabric only uses it for next-cycle choices.
        in_latency_d = sat_latency(count_q);

        if (push_s) begin
            mem_d[wr_ptr_q] = bus.in_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state with synchronous reset; stored words are discarded by clearing occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= {PTR_W{1'b0}};
            rd_ptr_q     <= {PTR_W{1'b0}};
            count_q      <= {CNT_W{1'b0}};
            in_latency_q <= {LATENCY_WIDTH{1'b0}};
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            in_latency_q <= in_latency_d;
        end
    end

    // Storage array; contents are meaningless unless covered by count, so no reset is needed.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.in_ready   = !full_s;
    assign bus.out_valid  = nonempty_s;
    assign bus.out_data   = mem_q[rd_ptr_q];
    assign bus.count      = count_q;
    assign bus.empty      = !nonempty_s;
    assign bus.in_latency = in_latency_q;

    channel_sink_buffer_chk #(
        .DEPTH         (DEPTH),
        .LATENCY_WIDTH (LATENCY_WIDTH)
    ) u_chk (
        .clk        (clk),
        .rst        (rst),
        .push       (push_s),
        .pop        (pop_s),
        .count      (count_q),
        .in_latency (in_latency_q)
    );
endmodule

// Protocol and occupancy properties of the sink buffer.
module channel_sink_buffer_chk #(
    parameter int DEPTH         = 8,
    parameter int LATENCY_WIDTH = 3
) (
    input logic                       clk,
    input logic                       rst,
    input logic                       push,
    input logic                       pop,
    input logic [$clog2(DEPTH):0]     count,
    input logic [LATENCY_WIDTH-1:0]   in_latency
);
    localparam int LAT_MAX = (1 << LATENCY_WIDTH) - 1;

    logic                   prev_valid_q;
    logic [$clog2(DEPTH):0] prev_count_q;

    // Remember the occupancy the metric was loaded from on the previous edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_valid_q <= 1'b0;
            prev_count_q <= '0;
        end else begin
            prev_valid_q <= 1'b1;
            prev_count_q <= count;
        end
    end

    // Immediate checks evaluated on every non-reset edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && (int'(count) == DEPTH)));
            assert (!(pop && (int'(count) == 0)));
            assert (int'(count) <= DEPTH);
            if (prev_valid_q) begin
                assert (int'(in_latency) ==
                        ((int'(prev_count_q) >= LAT_MAX) ? LAT_MAX : int'(prev_count_q)));
            end else begin
                assert (int'(in_latency) == 0);
            end
        end else begin
            assert (int'(count) <= DEPTH);
        end
    end
endmodule
